// File: rtl/byte_ram_lsu_bridge.sv
// Load/store sequencer for a byte-wide RAM: splits byte/half/word requests
// into single-byte RAM cycles and returns one extended, little-endian response.
module byte_ram_lsu_bridge #(
  parameter int SIZE       = 4096,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and req_* are ignored whenever it is low.
  // resp_valid is a one-cycle strobe with no backpressure.
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_wenable,
  input  logic [7:0]            ram_rdata,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic                  r_unsigned;
  logic                  r_err;
  logic [1:0]            r_size;
  logic [1:0]            r_cnt;
  logic [1:0]            r_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;

  logic [32:0]           w_nbytes;
  logic [32:0]           w_end;
  logic [1:0]            w_last;
  logic                  w_err;
  logic                  w_sign;

  // Range check is done at 33 bits so an address near 2^32 cannot wrap into range.
  always_comb begin
    w_last   = 2'd0;
    w_nbytes = 33'd1;
    case (req_size)
      2'd1: begin
        w_last   = 2'd1;
        w_nbytes = 33'd2;
      end
      2'd2: begin
        w_last   = 2'd3;
        w_nbytes = 33'd4;
      end
      default: ;
    endcase
    w_end = {1'b0, req_addr} + w_nbytes;
    w_err = (req_size == 2'd3)
          | ((req_size == 2'd1) & req_addr[0])
          | ((req_size == 2'd2) & (|req_addr[1:0]))
          | (w_end > 33'(SIZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'd0;
      r_cnt      <= 2'd0;
      r_last     <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr[ADDR_WIDTH-1:0];
            r_wdata    <= req_wdata;
            r_cnt      <= 2'd0;
            r_last     <= w_last;
            r_err      <= w_err;
            r_buf      <= 32'd0;
            r_state    <= w_err ? S_RESP : S_XFER;
          end
        end
        S_XFER: begin
          if (!r_write) begin
            r_buf[{r_cnt, 3'b000} +: 8] <= ram_rdata;
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == r_last) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_cnt   <= 2'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_sign = ~r_unsigned & ((r_size == 2'd0) ? r_buf[7] : r_buf[15]);

  // Every output below depends only on registered state.
  always_comb begin
    req_ready   = (r_state == S_IDLE);
    resp_valid  = (r_state == S_RESP);
    resp_err    = (r_state == S_RESP) & r_err;
    resp_rdata  = 32'd0;
    ram_addr    = '0;
    ram_wdata   = 8'd0;
    ram_wenable = 1'b0;
    if ((r_state == S_RESP) && !r_err && !r_write) begin
      case (r_size)
        2'd0:    resp_rdata = {{24{w_sign}}, r_buf[7:0]};
        2'd1:    resp_rdata = {{16{w_sign}}, r_buf[15:0]};
        default: resp_rdata = r_buf;
      endcase
    end
    if (r_state == S_XFER) begin
      ram_addr    = r_addr + ADDR_WIDTH'(r_cnt);
      ram_wenable = r_write;
      if (r_write) begin
        ram_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_byte_ram_lsu_bridge.sv
// Bench for byte_ram_lsu_bridge: directed vector table, reset-abort sequence,
// and random traffic against a byte-array reference model.
module tb_byte_ram_lsu_bridge;

  localparam int SIZE = 4096;
  localparam int AW   = $clog2(SIZE);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_wenable;
  logic [7:0]    ram_rdata;
  logic [1:0]    dbg_state;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  ram [SIZE] = '{default: 8'h00};
  logic [7:0]  ref_mem [SIZE] = '{default: 8'h00};
  int          n_vec = 0;
  int          n_miss = 0;

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wenable) ram[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = ram[ram_addr];

  byte_ram_lsu_bridge #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wenable  (ram_wenable),
    .ram_rdata    (ram_rdata),
    .o_dbg_state  (dbg_state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  // Reference: byte array with arithmetic little-endian assembly and extension.
  task automatic model_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata, output int nb);
    longint unsigned a = 64'(addr);
    longint unsigned v = 0;
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    rdata = 32'd0;
    if (nb == 0) err = 1'b1;
    else err = ((a % longint'(nb)) != 0) || (a + longint'(nb) > longint'(SIZE));
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (wr) ref_mem[a + i] = 8'(wdata >> (8 * i));
        else    v += longint'(ref_mem[a + i]) << (8 * i);
      end
      if (!wr) begin
        if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
          v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
        rdata = v[31:0];
      end
    end
  endtask

  task automatic scramble();
    req_valid    = 1'($urandom_range(0, 1));
    req_write    = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata,
                        output int cyc, output int wen);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    cyc = 0; wen = 0; err = 1'b0; rdata = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ram_wenable) wen++;
      if (resp_valid) begin
        cyc   = c;
        err   = resp_err;
        rdata = resp_rdata;
        check("ram_quiet_in_resp", 32'({ram_wenable, ram_addr, ram_wdata}), 32'd0);
        req_valid = 1'b0;
        break;
      end
      scramble();
    end
    if (cyc == 0) begin
      check("resp_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic        m_err, d_err;
    logic [31:0] m_rd, d_rd;
    int          nb, cyc, wen, nbt, bad;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp", 32'({resp_valid, resp_err}), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_ram", 32'({ram_wenable, ram_addr, ram_wdata}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0));
    tbl.push_back(mk(0, 2, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 0, 32'h20, 32'h777777_80, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h21, 32'h123456_FF, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h20, 32'h0, 0, 32'hFFFFFF80));
    tbl.push_back(mk(0, 0, 1, 32'h20, 32'h0, 0, 32'h00000080));
    tbl.push_back(mk(0, 1, 0, 32'h20, 32'h0, 0, 32'hFFFFFF80));
    tbl.push_back(mk(0, 1, 1, 32'h20, 32'h0, 0, 32'h0000FF80));
    tbl.push_back(mk(1, 1, 0, 32'h31, 32'hFFFF, 1, 32'h0));
    tbl.push_back(mk(0, 2, 0, 32'h32, 32'h0, 1, 32'h0));
    tbl.push_back(mk(0, 3, 0, 32'h00, 32'h0, 1, 32'h0));
    tbl.push_back(mk(0, 2, 0, 32'(SIZE - 4), 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, 2, 0, 32'(SIZE), 32'h0, 1, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'hFFFF_FFFF, 32'hAA, 1, 32'h0));
    tbl.push_back(mk(1, 2, 0, 32'h40, 32'h11223344, 0, 32'h0));
    tbl.push_back(mk(1, 0, 0, 32'h41, 32'h555555AB, 0, 32'h0));
    tbl.push_back(mk(0, 2, 0, 32'h40, 32'h0, 0, 32'h1122AB44));
    tbl.push_back(mk(0, 1, 1, 32'h12, 32'h0, 0, 32'h0000DEAD));
    tbl.push_back(mk(0, 0, 0, 32'h13, 32'h0, 0, 32'hFFFFFFDE));
    tbl.push_back(mk(1, 1, 0, 32'(SIZE - 2), 32'hABCD1234, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'(SIZE - 2), 32'h0, 0, 32'h00001234));
    tbl.push_back(mk(0, 2, 0, 32'(SIZE - 4), 32'h0, 0, 32'h12340000));

    foreach (tbl[i]) begin
      model_req(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, m_err, m_rd, nb);
      do_req(tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, d_err, d_rd, cyc, wen);
      nbt = 1 << tbl[i].sz;
      check("tbl_err", 32'(d_err), 32'(tbl[i].err));
      check("tbl_rdata", d_rd, tbl[i].rdata);
      check("tbl_resp_cycle", 32'(cyc), tbl[i].err ? 32'd1 : 32'(nbt + 1));
      check("tbl_wen_count", 32'(wen), (tbl[i].wr && !tbl[i].err) ? 32'(nbt) : 32'd0);
    end
    check("word_store_bytes", {ram[32'h13], ram[32'h12], ram[32'h11], ram[32'h10]}, 32'hDEADBEEF);

    // Reset during XFER cycle 2 of a word store.
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h80; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_wen_c1", 32'(ram_wenable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_after_rst", 32'(req_ready), 32'd1);
    check("abort_no_resp", 32'({resp_valid, ram_wenable}), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_quiet", 32'({resp_valid, ram_wenable}), 32'd0);
    end
    check("abort_ram", {ram[32'h83], ram[32'h82], ram[32'h81], ram[32'h80]}, 32'h0000F00D);
    ref_mem[32'h80] = 8'h0D;
    ref_mem[32'h81] = 8'hF0;

    // Random traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      logic        wr, uns;
      logic [1:0]  sz;
      logic [31:0] addr, wdata;
      int          pick;
      wr    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      pick  = $urandom_range(0, 9);
      sz    = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
      pick  = $urandom_range(0, 9);
      addr  = (pick < 8) ? 32'($urandom_range(0, 63)) :
              (pick == 8) ? 32'(SIZE - 8 + $urandom_range(0, 11)) : $urandom;
      wdata = $urandom;
      model_req(wr, sz, uns, addr, wdata, m_err, m_rd, nb);
      do_req(wr, sz, uns, addr, wdata, d_err, d_rd, cyc, wen);
      check("rnd_err", 32'(d_err), 32'(m_err));
      check("rnd_rdata", d_rd, m_rd);
      check("rnd_resp_cycle", 32'(cyc), m_err ? 32'd1 : 32'(nb + 1));
      check("rnd_wen_count", 32'(wen), (wr && !m_err) ? 32'(nb) : 32'd0);
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (ram[i] !== ref_mem[i]) bad++;
    end
    check("mem_final_bad_bytes", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
